ws2812_encoder: RTL and testbench



---
 rtl/ws2812_encoder_if.sv | 10 +
 rtl/ws2812_encoder.sv | 186 ++++++++++++++++++
 tb/tb_ws2812_encoder.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ws2812_encoder_if.sv
// Byte stream into the WS2812 encoder. A byte moves on a rising clock edge
// where data_valid and data_ready are both high.
interface ws2812_encoder_if;
    logic [7:0] data_in;
    logic       data_valid;
    logic       data_ready;

    modport master (output data_in, output data_valid, input data_ready);
    modport slave  (input data_in, input data_valid, output data_ready);
endinterface

// File: rtl/ws2812_encoder.sv
// WS2812 one-wire encoder: serialises pixel bytes MSB first onto a strip data
// line. A one-byte holding register keeps back-to-back bytes gap-free, and a
// frame_end pulse latches the strip once queued data has drained.
// Optional build macro WS2812_OUT_INVERT_EN drives the line inverted (idle
// high) for inverting line drivers. Internal timing is unchanged.
module ws2812_encoder #(
    parameter int T0H_CYCLES   = 20,
    parameter int T1H_CYCLES   = 40,
    parameter int BIT_CYCLES   = 62,
    parameter int LATCH_CYCLES = 2600,
    parameter int CNT_W        = 16
) (
    input  logic            clk,
    input  logic            reset,
    ws2812_encoder_if.slave in_if,
    input  logic            frame_end,
    input  logic            clr_underrun,
    output logic            led_out,
    output logic            busy,
    output logic            underrun
);

`ifdef WS2812_OUT_INVERT_EN
    localparam logic LINE_INV = 1'b1;
`else
    localparam logic LINE_INV = 1'b0;
`endif

    // Terminal counts: each phase lasts (last + 1) cycles.
    localparam logic [CNT_W-1:0] T0H_LAST   = CNT_W'(T0H_CYCLES - 1);
    localparam logic [CNT_W-1:0] T1H_LAST   = CNT_W'(T1H_CYCLES - 1);
    localparam logic [CNT_W-1:0] T0L_LAST   = CNT_W'(BIT_CYCLES - T0H_CYCLES - 1);
    localparam logic [CNT_W-1:0] T1L_LAST   = CNT_W'(BIT_CYCLES - T1H_CYCLES - 1);
    localparam logic [CNT_W-1:0] LATCH_LAST = CNT_W'(LATCH_CYCLES - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_HIGH, ST_LOW, ST_LATCH} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       hold_q, hold_d;
    logic             hold_full_q, hold_full_d;
    logic             frame_pend_q, frame_pend_d;
    logic             underrun_q, underrun_d;
    logic             led_q, led_d;
    logic             ready_q, ready_d;
    logic             busy_q, busy_d;

    logic             accept;
    logic             high_last;
    logic             low_last;
    logic             line;
    logic             set_underrun;

    assign accept    = in_if.data_valid & ready_q;
    assign high_last = shift_q[7] ? (cnt_q == T1H_LAST) : (cnt_q == T0H_LAST);
    assign low_last  = shift_q[7] ? (cnt_q == T1L_LAST) : (cnt_q == T0L_LAST);

    // Next-state, datapath and output decode for the bit-timing FSM.
    always_comb begin
        // NOTE: every signal gets a default before any branch, so no path leaves
        // a value unassigned and no latch is inferred.
        state_d      = state_q;
        cnt_d        = cnt_q + 1'b1;
        idx_d        = idx_q;
        shift_d      = shift_q;
        hold_d       = hold_q;
        hold_full_d  = hold_full_q;
        frame_pend_d = frame_pend_q | frame_end;
        set_underrun = 1'b0;
        line         = 1'b0;

        // Accept is legal in every state; it never coincides with a reload
        // because ready is only high while the holding register is empty.
        if (accept) begin
            hold_d      = in_if.data_in;
            hold_full_d = 1'b1;
        end

        unique case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (hold_full_q) begin
                    shift_d     = hold_q;
                    hold_full_d = 1'b0;
                    idx_d       = 3'd7;
                    state_d     = ST_HIGH;
                    line        = 1'b1;
                end else if (frame_pend_q) begin
                    frame_pend_d = 1'b0;
                    state_d      = ST_LATCH;
                end
            end

            ST_HIGH: begin
                line = 1'b1;
                if (high_last) begin
                    cnt_d   = '0;
                    state_d = ST_LOW;
                    line    = 1'b0;
                end
            end

            ST_LOW: begin
                if (low_last) begin
                    cnt_d = '0;
                    if (idx_q != 3'd0) begin
                        shift_d = {shift_q[6:0], 1'b0};
                        idx_d   = idx_q - 3'd1;
                        state_d = ST_HIGH;
                        line    = 1'b1;
                    end else if (hold_full_q) begin
                        // Reload with no gap: next rise lands one bit period on.
                        shift_d     = hold_q;
                        hold_full_d = 1'b0;
                        idx_d       = 3'd7;
                        state_d     = ST_HIGH;
                        line        = 1'b1;
                    end else if (frame_pend_q) begin
                        frame_pend_d = 1'b0;
                        state_d      = ST_LATCH;
                    end else begin
                        set_underrun = 1'b1;
                        frame_pend_d = 1'b0;
                        state_d      = ST_LATCH;
                    end
                end
            end

            ST_LATCH: begin
                if (cnt_q == LATCH_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end
            end

            default: begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase

        // A new underrun wins over a simultaneous clear.
        underrun_d = (underrun_q & ~clr_underrun) | set_underrun;
        led_d      = line ^ LINE_INV;
        ready_d    = ~hold_full_d;
        busy_d     = (state_d != ST_IDLE);
    end

    // State and registered outputs, with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (!reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            idx_q        <= '0;
            shift_q      <= '0;
            hold_q       <= '0;
            hold_full_q  <= 1'b0;
            frame_pend_q <= 1'b0;
            underrun_q   <= 1'b0;
            led_q        <= LINE_INV;
            ready_q      <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            shift_q      <= shift_d;
            hold_q       <= hold_d;
            hold_full_q  <= hold_full_d;
            frame_pend_q <= frame_pend_d;
            underrun_q   <= underrun_d;
            led_q        <= led_d;
            ready_q      <= ready_d;
            busy_q       <= busy_d;
        end
    end

    assign in_if.data_ready = ready_q;
    assign led_out          = led_q;
    assign busy             = busy_q;
    assign underrun         = underrun_q;

endmodule

// File: tb/tb_ws2812_encoder.sv
// Self-checking bench for ws2812_encoder. A monitor timestamps line and busy
// transitions; expected waveforms come from the bit-level timing rules
// (high time by bit value, fixed bit pitch, latch length after a frame).
module tb_ws2812_encoder;
    localparam int T0H   = 20;
    localparam int T1H   = 40;
    localparam int BITC  = 62;
    localparam int LATCH = 2600;
    localparam int CNT_W = 16;

`ifdef WS2812_OUT_INVERT_EN
    localparam logic INV = 1'b1;
`else
    localparam logic INV = 1'b0;
`endif

    logic clk          = 1'b0;
    logic reset        = 1'b0;
    logic frame_end    = 1'b0;
    logic clr_underrun = 1'b0;
    logic led_out;
    logic busy;
    logic underrun;

    ws2812_encoder_if bus ();

    ws2812_encoder #(
        .T0H_CYCLES  (T0H),
        .T1H_CYCLES  (T1H),
        .BIT_CYCLES  (BITC),
        .LATCH_CYCLES(LATCH),
        .CNT_W       (CNT_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .in_if       (bus),
        .frame_end   (frame_end),
        .clr_underrun(clr_underrun),
        .led_out     (led_out),
        .busy        (busy),
        .underrun    (underrun)
    );

    always #10 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    int   rises[$];
    int   falls[$];
    int   busy_rises[$];
    int   busy_falls[$];
    logic exp_bits[$];
    logic prev_line = 1'b0;
    logic prev_busy = 1'b0;

    typedef struct {
        logic [7:0] data;
        logic       fe;
        int         exp_high;
        logic       exp_und;
    } vec_t;

    vec_t tbl[5];

    always @(posedge clk) cyc <= cyc + 1;

    // Timestamp transitions of the logical line level and of busy.
    always @(negedge clk) begin
        logic ln;
        ln = led_out ^ INV;
        if (ln && !prev_line) rises.push_back(cyc);
        if (!ln && prev_line) falls.push_back(cyc);
        if (busy && !prev_busy) busy_rises.push_back(cyc);
        if (!busy && prev_busy) busy_falls.push_back(cyc);
        prev_line = ln;
        prev_busy = busy;
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b", name, act, exp);
    endtask

    task automatic clear_mon();
        @(posedge clk);
        rises.delete();
        falls.delete();
        busy_rises.delete();
        busy_falls.delete();
    endtask

    task automatic push_bits(input logic [7:0] d);
        for (int k = 7; k >= 0; k--) exp_bits.push_back(d[k]);
    endtask

    // Present a byte and hold it until accepted; returns the accept-edge stamp.
    task automatic send_byte(input logic [7:0] d, output int acc);
        int g;
        g = 0;
        @(negedge clk);
        bus.data_in    = d;
        bus.data_valid = 1'b1;
        while (!bus.data_ready && g < 2000) begin
            @(negedge clk);
            g++;
        end
        check1($sformatf("accept 0x%02h in time", d), g < 2000, 1'b1);
        @(posedge clk);
        @(negedge clk);
        acc            = cyc;
        bus.data_valid = 1'b0;
    endtask

    task automatic pulse_frame_end();
        frame_end = 1'b1;
        @(negedge clk);
        frame_end = 1'b0;
    endtask

    // Wait for the frame's latch to finish, then compare against exp_bits.
    task automatic check_frame(input string name, input int nbits, input logic exp_und);
        int g;
        g = 0;
        while (busy_falls.size() == 0 && g < nbits * BITC + LATCH + 1000) begin
            @(negedge clk);
            g++;
        end
        check1({name, " frame done"}, busy_falls.size() > 0, 1'b1);
        check({name, " bit count"}, rises.size(), nbits);
        if (rises.size() == nbits && falls.size() >= nbits && busy_falls.size() > 0) begin
            for (int i = 0; i < nbits; i++) begin
                check($sformatf("%s bit%0d high", name, i), falls[i] - rises[i],
                      exp_bits[i] ? T1H : T0H);
                if (i > 0)
                    check($sformatf("%s bit%0d pitch", name, i), rises[i] - rises[i-1], BITC);
            end
            check({name, " last bit + latch"}, busy_falls[0] - rises[nbits-1], BITC + LATCH);
        end
        check1({name, " underrun"}, underrun, exp_und);
        check1({name, " idle level"}, led_out, INV);
    endtask

    initial begin
        int acc;
        int acc2;
        int g;
        int sum;

        tbl[0] = '{8'hA5, 1'b1, 240, 1'b0};
        tbl[1] = '{8'h00, 1'b1, 160, 1'b0};
        tbl[2] = '{8'hFF, 1'b1, 320, 1'b0};
        tbl[3] = '{8'h01, 1'b0, 180, 1'b1};
        tbl[4] = '{8'h81, 1'b1, 200, 1'b0};

        bus.data_in    = 8'h00;
        bus.data_valid = 1'b0;

        // Reset values.
        repeat (3) @(negedge clk);
        check1("reset led_out", led_out, INV);
        check1("reset data_ready", bus.data_ready, 1'b0);
        check1("reset busy", busy, 1'b0);
        check1("reset underrun", underrun, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        check1("ready after release", bus.data_ready, 1'b1);

        // Table-driven single-byte frames.
        for (int r = 0; r < 5; r++) begin
            clear_mon();
            exp_bits.delete();
            push_bits(tbl[r].data);
            send_byte(tbl[r].data, acc);
            if (tbl[r].fe) pulse_frame_end();
            check_frame($sformatf("vec%0d 0x%02h", r, tbl[r].data), 8, tbl[r].exp_und);
            if (r == 0 && rises.size() > 0)
                check("first rise latency", rises[0] - acc, 1);
            sum = 0;
            for (int i = 0; i < rises.size() && i < falls.size(); i++) sum += falls[i] - rises[i];
            check($sformatf("vec%0d total high", r), sum, tbl[r].exp_high);
            if (tbl[r].exp_und) begin
                @(negedge clk);
                clr_underrun = 1'b1;
                @(negedge clk);
                clr_underrun = 1'b0;
                check1("underrun cleared", underrun, 1'b0);
            end
        end

        // Back-to-back 0xFF, 0x00 with the second byte queued while shifting.
        clear_mon();
        exp_bits.delete();
        push_bits(8'hFF);
        push_bits(8'h00);
        send_byte(8'hFF, acc);
        send_byte(8'h00, acc2);
        check1("b2b ready low after 2nd accept", bus.data_ready, 1'b0);
        g = 0;
        while (!bus.data_ready && g < 1000) begin
            @(negedge clk);
            g++;
        end
        if (rises.size() > 0)
            check("b2b ready returns at reload", cyc - rises[0], 8 * BITC);
        else
            check("b2b first byte started", rises.size(), 1);
        pulse_frame_end();
        check_frame("b2b FF00", 16, 1'b0);

        // frame_end while idle and empty: latch only.
        clear_mon();
        @(negedge clk);
        pulse_frame_end();
        g = 0;
        while (busy_falls.size() == 0 && g < LATCH + 200) begin
            @(negedge clk);
            g++;
        end
        check("idle latch busy pulses", busy_rises.size() + busy_falls.size(), 2);
        if (busy_rises.size() > 0 && busy_falls.size() > 0)
            check("idle latch busy length", busy_falls[0] - busy_rises[0], LATCH);
        check("idle latch no line pulse", rises.size(), 0);
        check1("idle latch line level", led_out, INV);

        // Reset mid-way through a 1-bit high phase with a byte held.
        clear_mon();
        send_byte(8'hFF, acc);
        send_byte(8'h00, acc2);
        repeat (15) @(negedge clk);
        check1("pre-reset mid high", led_out, ~INV);
        reset = 1'b0;
        @(negedge clk);
        check1("mid reset led_out", led_out, INV);
        check1("mid reset busy", busy, 1'b0);
        check1("mid reset data_ready", bus.data_ready, 1'b0);
        check1("mid reset underrun", underrun, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        check1("mid reset ready after release", bus.data_ready, 1'b1);
        clear_mon();
        repeat (700) @(negedge clk);
        check("held byte discarded", rises.size(), 0);
        check1("after reset busy", busy, 1'b0);

        // Randomised multi-byte frames with random inter-byte gaps.
        for (int f = 0; f < 4; f++) begin
            int         nb;
            logic [7:0] d;
            nb = $urandom_range(1, 3);
            clear_mon();
            exp_bits.delete();
            repeat ($urandom_range(0, 20)) @(negedge clk);
            for (int b = 0; b < nb; b++) begin
                d = 8'($urandom);
                if (b > 0) repeat ($urandom_range(0, 150)) @(negedge clk);
                push_bits(d);
                send_byte(d, acc);
            end
            pulse_frame_end();
            check_frame($sformatf("rand%0d", f), nb * 8, 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
